opt_check_sequencer: RTL and testbench

Self-checking stimulus sequencer for small combinational optimisation-check cells (opt_check family: y = f(a,b,...)). On a start pulse it sweeps every input vector through the cell under test. It holds each vector for a programmable settle time, samples the cell output and compares it against a truth-table parameter. It then reports a mismatch count, the first failing vector and a pass flag, so a synthesised or gate-level netlist can be checked in-circuit without a waveform viewer.

---
 rtl/opt_seq_pkg.sv | 14 +
 rtl/opt_seq_settle_cnt.sv | 36 +++
 rtl/opt_check_sequencer.sv | 137 +++++++++++++
 tb/tb_opt_check_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/opt_seq_pkg.sv
// Shared types and constants for the opt_check sweep sequencer.
// Build option OPT_SEQ_STOP_ON_FAIL_EN (used by opt_check_sequencer) ends a sweep on its first mismatch.
package opt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] TRUTH_OR  = 4'b1110;
  localparam logic [3:0] TRUTH_AND = 4'b1000;

endpackage

// File: rtl/opt_seq_settle_cnt.sv
// Hold-time counter: counts 0..SETTLE-1 while enabled and flags the last hold cycle.
module opt_seq_settle_cnt #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] r_cnt;

  // Count while enabled; wrap at the terminal count so each vector gets a fresh hold window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_en) begin
      if (r_cnt == LAST) begin
        r_cnt <= {CW{1'b0}};
      end else begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/opt_check_sequencer.sv
// Sweeps every input vector through a combinational cell, compares against TRUTH and reports results.
// Define OPT_SEQ_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module opt_check_sequencer
  import opt_seq_pkg::*;
#(
  parameter int                  N_IN   = 2,
  parameter int                  SETTLE = 2,
  parameter logic [2**N_IN-1:0]  TRUTH  = TRUTH_OR
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            y_i,
  output logic [N_IN-1:0] vec_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            fail_seen,
  output logic [N_IN-1:0] fail_vec
);

  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

  state_t          r_state, w_state_nxt;
  logic [N_IN-1:0] r_vec, w_vec_nxt;
  logic [N_IN:0]   r_err, w_err_nxt;
  logic            r_fseen, w_fseen_nxt;
  logic [N_IN-1:0] r_fvec, w_fvec_nxt;
  logic            r_pass, w_pass_nxt;
  logic            r_busy, r_done;
  logic            w_tc, w_mis, w_end;

  opt_seq_settle_cnt #(.SETTLE(SETTLE)) u_settle (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (r_state != DRIVE),
    .i_en    (r_state == DRIVE),
    .o_tc    (w_tc)
  );

  // Next-state and result update; results only change on a start or a sample edge
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_err_nxt   = r_err;
    w_fseen_nxt = r_fseen;
    w_fvec_nxt  = r_fvec;
    w_pass_nxt  = r_pass;
    w_mis       = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = DRIVE;
          w_vec_nxt   = {N_IN{1'b0}};
          w_err_nxt   = {(N_IN+1){1'b0}};
          w_fseen_nxt = 1'b0;
          w_fvec_nxt  = {N_IN{1'b0}};
          w_pass_nxt  = 1'b0;
        end else begin
          w_vec_nxt = {N_IN{1'b0}};
        end
      end
      DRIVE: begin
        if (w_tc) begin
          w_mis = (y_i != TRUTH[r_vec]);
          if (w_mis) begin
            w_err_nxt = r_err + {{N_IN{1'b0}}, 1'b1};
            if (!r_fseen) begin
              w_fseen_nxt = 1'b1;
              w_fvec_nxt  = r_vec;
            end else begin
              w_fvec_nxt  = r_fvec;
            end
          end else begin
            w_err_nxt = r_err;
          end
`ifdef OPT_SEQ_STOP_ON_FAIL_EN
          w_end = w_mis || (r_vec == LAST_VEC);
`else
          w_end = (r_vec == LAST_VEC);
`endif
          if (w_end) begin
            w_state_nxt = DONE;
            w_pass_nxt  = (w_err_nxt == {(N_IN+1){1'b0}});
          end else begin
            w_vec_nxt = r_vec + {{(N_IN-1){1'b0}}, 1'b1};
          end
        end else begin
          w_state_nxt = DRIVE;
        end
      end
      DONE: begin
        // vec_o stays frozen through the DONE cycle, then returns to 0 in IDLE
        w_state_nxt = IDLE;
        w_vec_nxt   = {N_IN{1'b0}};
      end
      default: begin
        w_state_nxt = IDLE;
        w_vec_nxt   = {N_IN{1'b0}};
      end
    endcase
  end

  // State, vector and result registers; busy/done are registered from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_vec   <= {N_IN{1'b0}};
      r_err   <= {(N_IN+1){1'b0}};
      r_fseen <= 1'b0;
      r_fvec  <= {N_IN{1'b0}};
      r_pass  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_err   <= w_err_nxt;
      r_fseen <= w_fseen_nxt;
      r_fvec  <= w_fvec_nxt;
      r_pass  <= w_pass_nxt;
      r_busy  <= (w_state_nxt == DRIVE);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  assign vec_o     = r_vec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err;
  assign fail_seen = r_fseen;
  assign fail_vec  = r_fvec;

endmodule

// File: tb/tb_opt_check_sequencer.sv
// Scoreboard bench for opt_check_sequencer: a default 2-input instance and a 3-input, SETTLE=1 instance.
module tb_opt_check_sequencer;
  import opt_seq_pkg::*;

  localparam int         N  = 2;
  localparam int         S  = 2;
  localparam logic [3:0] TT = TRUTH_OR;
`ifdef OPT_SEQ_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, cell_and = 1'b0;
  logic [1:0] vec, fvec;
  logic       y, busy, done, pass, fseen;
  logic [2:0] err;

  logic       start3 = 1'b0;
  logic [2:0] vec3, fvec3;
  logic       y3, busy3, done3, pass3, fseen3;
  logic [3:0] err3;

  assign y  = cell_and ? (&vec) : (|vec);
  assign y3 = |vec3;

  always #5 clk = ~clk;

  opt_check_sequencer #(.N_IN(N), .SETTLE(S), .TRUTH(TT)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .y_i(y), .vec_o(vec),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err),
    .fail_seen(fseen), .fail_vec(fvec)
  );

  opt_check_sequencer #(.N_IN(3), .SETTLE(1), .TRUTH(8'hFE)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .y_i(y3), .vec_o(vec3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .fail_seen(fseen3), .fail_vec(fvec3)
  );

  typedef struct {
    int err;
    int fvec;
    int fseen;
    int pass;
    int len;
    int vlast;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input bit and_cell);
    exp_t e;
    bit   yv;
    e = '{err: 0, fvec: 0, fseen: 0, pass: 0, len: 0, vlast: 0};
    for (int v = 0; v < 4; v++) begin
      yv = and_cell ? (v == 3) : (v != 0);
      e.len  += S;
      e.vlast = v;
      if (yv != TT[v]) begin
        e.err++;
        if (e.fseen == 0) begin
          e.fseen = 1;
          e.fvec  = v;
        end
        if (STOP) break;
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic do_sweep(input bit and_cell, input bit glitch);
    exp_t e;
    int   cyc;
    cell_and = and_cell;
    sb.push_back(model(and_cell));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      chk("vec_step", vec, cyc / S);
      cyc++;
      start = (glitch && cyc == 3);
      @(negedge clk);
    end
    start = 1'b0;
    e = sb.pop_front();
    chk("busy_len", cyc, e.len);
    chk("done_pulse", done, 1);
    chk("err_cnt", err, e.err);
    chk("pass", pass, e.pass);
    chk("fail_seen", fseen, e.fseen);
    if (e.fseen != 0) chk("fail_vec", fvec, e.fvec);
    chk("vec_at_done", vec, e.vlast);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_vec", vec, 0);
    chk("hold_err", err, e.err);
    chk("hold_pass", pass, e.pass);
  endtask

  initial begin
    int t1, t2, n, cyc;
    #1;
    chk("reset_outs", {vec, busy, done, pass, err, fseen, fvec}, 0);
    chk("reset_outs3", {vec3, busy3, done3, pass3, err3, fseen3, fvec3}, 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);

    do_sweep(1'b0, 1'b0);
    chk("or_err_lit", err, 0);
    do_sweep(1'b1, 1'b0);
    chk("and_fvec_lit", fvec, 1);
    do_sweep(1'b0, 1'b1);

    // Back-to-back sweeps with start held high
    cell_and = 1'b0;
    t1 = -1; t2 = -1; n = 0;
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < 60 && t2 < 0; i++) begin
      @(negedge clk);
      if (done) begin
        if (t1 < 0) t1 = i; else t2 = i;
      end
    end
    start = 1'b0;
    chk("b2b_seen", (t2 >= 0), 1);
    chk("b2b_gap", t2 - t1, 10);
    repeat (3) @(negedge clk);
    chk("b2b_idle", busy, 0);

    // Asynchronous reset mid-sweep
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (vec != 2'd2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_vec2", vec, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_outs", {vec, busy, done, pass, err, fseen, fvec}, 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_vec", vec, 0);
    do_sweep(1'b0, 1'b0);

    // N_IN=3, SETTLE=1 instance
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    cyc = 0;
    while (busy3 && cyc < 100) begin
      chk("n3_vec_step", vec3, cyc);
      cyc++;
      @(negedge clk);
    end
    chk("n3_busy_len", cyc, 8);
    chk("n3_done", done3, 1);
    chk("n3_pass", pass3, 1);
    chk("n3_err", err3, 0);
    chk("n3_fseen", fseen3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
